// File: rtl/cfu_cmd_initiator.sv
// CPU-side initiator for the CFU command/response bus.
// Host commands are queued in a command FIFO; an FSM issues them one at a time
// to the CFU and queues returned words (when requested) in a response FIFO.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   cmd_in_*                       host command push side (valid/ready + fields)
//   rsp_out_*                      host response pop side (valid/ready + data)
//   cmd_valid/cmd_ready/cmd_payload_*   CFU command channel
//   rsp_valid/rsp_ready/rsp_payload_outputs_0  CFU response channel
//   busy                           FSM active or commands pending
//   timeout_err, clear_err         sticky response-timeout flag and its clear
module cfu_cmd_initiator #(
  parameter int unsigned CMD_DEPTH      = 8,
  parameter int unsigned RSP_DEPTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_in_valid,
  output logic        cmd_in_ready,
  input  logic [6:0]  cmd_in_funct7,
  input  logic [2:0]  cmd_in_funct3,
  input  logic [31:0] cmd_in_op0,
  input  logic [31:0] cmd_in_op1,
  input  logic        cmd_in_want_rsp,
  output logic        rsp_out_valid,
  input  logic        rsp_out_ready,
  output logic [31:0] rsp_out_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clear_err
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned RAW = $clog2(RSP_DEPTH);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CAW:0]  CmdFull  = (CAW + 1)'(CMD_DEPTH);
  localparam logic [RAW:0]  RspFull  = (RAW + 1)'(RSP_DEPTH);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op0;
    logic [31:0] op1;
    logic        want_rsp;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

  // Command FIFO
  cmd_t           cmd_mem_q [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
  logic [CAW:0]   cmd_count_q, cmd_count_d;
  logic           cmd_push, cmd_pop, cmd_empty;
  cmd_t           cmd_head, cmd_in;

  // Response FIFO
  logic [31:0]    rsp_mem_q [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr_q, rsp_rd_ptr_q;
  logic [RAW:0]   rsp_count_q, rsp_count_d;
  logic           rsp_push, rsp_pop;

  // FSM and issue-stage registers
  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  cmd_t           issue_q, issue_d;
  logic           cmd_valid_q, rsp_ready_q, busy_q, timeout_err_q;
  logic           timeout_set, rsp_hs;

  assign cmd_in       = '{funct7: cmd_in_funct7, funct3: cmd_in_funct3, op0: cmd_in_op0,
                          op1: cmd_in_op1, want_rsp: cmd_in_want_rsp};
  assign cmd_empty    = (cmd_count_q == '0);
  assign cmd_in_ready = (cmd_count_q != CmdFull);
  assign cmd_push     = cmd_in_valid & cmd_in_ready;
  assign cmd_head     = cmd_mem_q[cmd_rd_ptr_q];

  assign rsp_out_valid = (rsp_count_q != '0);
  assign rsp_out_data  = rsp_mem_q[rsp_rd_ptr_q];
  assign rsp_pop       = rsp_out_ready & rsp_out_valid;
  assign rsp_hs        = rsp_valid & rsp_ready_q;

  always_comb begin
    unique case ({cmd_push, cmd_pop})
      2'b10:   cmd_count_d = cmd_count_q + 1'b1;
      2'b01:   cmd_count_d = cmd_count_q - 1'b1;
      default: cmd_count_d = cmd_count_q;
    endcase
    unique case ({rsp_push, rsp_pop})
      2'b10:   rsp_count_d = rsp_count_q + 1'b1;
      2'b01:   rsp_count_d = rsp_count_q - 1'b1;
      default: rsp_count_d = rsp_count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    issue_d     = issue_q;
    cmd_pop     = 1'b0;
    rsp_push    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          issue_d = cmd_head;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          timer_d = '0;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (rsp_hs) begin
          rsp_push = issue_q.want_rsp;
          state_d  = StIdle;
        end else if (timer_q == TimerMax) begin
          // Abandon the command; a late response is discarded from IDLE.
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      issue_q       <= '0;
      cmd_valid_q   <= 1'b0;
      rsp_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cmd_wr_ptr_q  <= '0;
      cmd_rd_ptr_q  <= '0;
      cmd_count_q   <= '0;
      rsp_wr_ptr_q  <= '0;
      rsp_rd_ptr_q  <= '0;
      rsp_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      issue_q     <= issue_d;
      cmd_valid_q <= (state_d == StIssue);
      // Back-pressure the CFU only when this command's word would have no slot.
      rsp_ready_q <= (state_d == StWaitRsp) ? !(issue_d.want_rsp && (rsp_count_d == RspFull))
                                            : 1'b1;
      busy_q        <= (state_d != StIdle) || (cmd_count_d != '0);
      timeout_err_q <= clear_err ? 1'b0 : (timeout_err_q | timeout_set);
      cmd_count_q   <= cmd_count_d;
      rsp_count_q   <= rsp_count_d;
      if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + 1'b1;
      if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + 1'b1;
      if (rsp_push) rsp_wr_ptr_q <= rsp_wr_ptr_q + 1'b1;
      if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_ptr_q] <= cmd_in;
    if (rsp_push) rsp_mem_q[rsp_wr_ptr_q] <= rsp_payload_outputs_0;
  end

  assign cmd_valid               = cmd_valid_q;
  assign cmd_payload_function_id = {issue_q.funct7, issue_q.funct3};
  assign cmd_payload_inputs_0    = issue_q.op0;
  assign cmd_payload_inputs_1    = issue_q.op1;
  assign rsp_ready               = rsp_ready_q;
  assign busy                    = busy_q;
  assign timeout_err             = timeout_err_q;

endmodule
